// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Optional BUSY watchdog: define SPI_ARB_TIMEOUT_EN to build the TIMEOUT counter and err reporting.
module spi_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*7-1:0]  req_bits,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic                  busy,
  output logic [31:0]           spi_data,
  output logic [6:0]            spi_bits,
  output logic                  spi_valid,
  input  logic [31:0]           spi_rdata,
  input  logic                  spi_done,
  input  logic                  spi_cs,
  output logic [NUM_REQ-1:0]    dev_cs
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_DONE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]      spi_data_q, spi_data_d;
  logic [6:0]       spi_bits_q, spi_bits_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             launch_ph_q, launch_ph_d;
  logic             timeout_hit;

  logic [31:0]      wdata_arr [NUM_REQ];
  logic [6:0]       bits_arr  [NUM_REQ];
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign wdata_arr[i] = req_wdata[32*i +: 32];
    assign bits_arr[i]  = req_bits[7*i +: 7];
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    spi_data_d  = spi_data_q;
    spi_bits_d  = spi_bits_q;
    rdata_d     = rdata_q;
    launch_ph_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          owner_d    = grant_idx;
          spi_data_d = wdata_arr[grant_idx];
          spi_bits_d = bits_arr[grant_idx];
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch_ph_d = 1'b1;
        if (launch_ph_q) begin
          launch_ph_d = 1'b0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        // A done arriving on the expiry cycle still counts as success.
        if (spi_done) begin
          rdata_d = spi_rdata;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rr_ptr_d = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
        state_d  = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      spi_data_q  <= '0;
      spi_bits_q  <= '0;
      rdata_q     <= '0;
      launch_ph_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      spi_data_q  <= spi_data_d;
      spi_bits_q  <= spi_bits_d;
      rdata_q     <= rdata_d;
      launch_ph_q <= launch_ph_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             err_q, err_d;

  // Held at zero outside BUSY, so the first BUSY cycle always sees zero.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_BUSY) to_cnt_d = to_cnt_q + 1'b1;
    err_d = (state_q == S_BUSY) && !spi_done && timeout_hit;
  end

  assign timeout_hit = (state_q == S_BUSY) && (to_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign busy      = (state_q == S_LAUNCH) || (state_q == S_BUSY) || (state_q == S_DONE);
  assign spi_valid = (state_q == S_LAUNCH);
  assign spi_data  = spi_data_q;
  assign spi_bits  = spi_bits_q;
  assign rdata     = rdata_q;

  always_comb begin
    ack    = '0;
    dev_cs = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state_q == S_DONE) && (owner_q == IDX_W'(i));
      if (!rst && busy && (owner_q == IDX_W'(i))) dev_cs[i] = spi_cs;
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized scoreboard bench for spi_arbiter: a transaction-level model predicts grants,
// launch windows, acks and read data; a negedge monitor compares every cycle.
module tb_spi_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;
  localparam int NCYC = 8000;

  typedef struct {
    int          idx;
    logic [31:0] wdata;
    logic [6:0]  bits;
    logic [31:0] rdata;
    int          g;
    int          d;
    bit          err;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*32-1:0]  req_wdata;
  logic [NR*7-1:0]   req_bits;
  logic [NR-1:0]     ack;
  logic [31:0]       rdata;
  logic              err;
  logic              busy;
  logic [31:0]       spi_data;
  logic [6:0]        spi_bits;
  logic              spi_valid;
  logic [31:0]       spi_rdata;
  logic              spi_done;
  logic              spi_cs;
  logic [NR-1:0]     dev_cs;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   acks_seen = 0;
  txn_t exp_q[$];

  spi_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wdata(req_wdata), .req_bits(req_bits),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy), .spi_data(spi_data),
    .spi_bits(spi_bits), .spi_valid(spi_valid), .spi_rdata(spi_rdata),
    .spi_done(spi_done), .spi_cs(spi_cs), .dev_cs(dev_cs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Stimulus, master stand-in and transaction-level reference model.
  initial begin
    txn_t          cur;
    logic [NR-1:0] req_v;
    bit            inflight, did_rst, busywin;
    int            free_from, rst_until, ptr, ntx, c, idx;
    cur = '{default: 0};
    req_v = '0; inflight = 0; did_rst = 0; busywin = 0;
    free_from = 4; rst_until = 4; ptr = 0; ntx = 0; idx = 0;
    rst = 1'b1; req = '0; req_wdata = '0; req_bits = '0;
    spi_rdata = '0; spi_done = 1'b0; spi_cs = 1'b1;
    repeat (NCYC) begin
      @(posedge clk); #2;
      c = cyc;
      if (inflight && c > cur.d + 1) begin
        inflight = 0;
        if (ntx > 5 && $urandom_range(1, 0) == 1) req_v[cur.idx] = 1'b0;
      end
      if (!did_rst && inflight && ntx == 20 && c == cur.g + 3) begin
        did_rst = 1; inflight = 0; ptr = 0;
        rst_until = c + 2; free_from = c + 2;
        exp_q.delete();
      end
      rst = (c < rst_until);

      if (ntx == 0) req_v = 4'b0100;
      else if (ntx <= 5) req_v = '1;
      else begin
        for (int i = 0; i < NR; i++) begin
          if (!req_v[i]) begin
            if ($urandom_range(3, 0) == 0) req_v[i] = 1'b1;
          end else if (inflight && i == cur.idx) begin
            if (c <= cur.d + 1 && $urandom_range(9, 0) == 0) req_v[i] = 1'b0;
          end else if ($urandom_range(29, 0) == 0) begin
            req_v[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_wdata[32*i +: 32] = $urandom;
        req_bits[7*i +: 7]    = 7'($urandom_range(127, 0));
      end
      if (ntx == 0) begin
        req_wdata[95:64] = 32'h0000A55A;
        req_bits[20:14]  = 7'd15;
      end

      spi_cs    = 1'($urandom_range(1, 0));
      busywin   = inflight && c >= cur.g + 3 && c <= cur.d;
      spi_done  = 1'b0;
      spi_rdata = $urandom;
      if (inflight && c == cur.d && !cur.err) begin
        spi_done  = 1'b1;
        spi_rdata = cur.rdata;
      end else if (!busywin && $urandom_range(7, 0) == 0) begin
        spi_done = 1'b1;
      end

      if (!rst && !inflight && c >= free_from && req_v != '0) begin
        idx = -1;
        for (int k = 0; k < NR; k++)
          if (idx < 0 && req_v[(ptr + k) % NR]) idx = (ptr + k) % NR;
        cur.idx   = idx;
        cur.wdata = req_wdata[32*idx +: 32];
        cur.bits  = req_bits[7*idx +: 7];
        cur.g     = c;
        cur.err   = 0;
        cur.d     = c + 3 + int'($urandom_range(15, 0));
        cur.rdata = (ntx == 0) ? 32'h1234 : $urandom;
`ifdef SPI_ARB_TIMEOUT_EN
        if (ntx % 7 == 6) begin
          cur.err = 1; cur.d = c + 3 + TO - 1; cur.rdata = '0;
        end
`endif
        exp_q.push_back(cur);
        inflight  = 1;
        ptr       = (idx + 1) % NR;
        free_from = cur.d + 3;
        ntx++;
      end
      req = req_v;
    end
    @(negedge clk); #1;
    chk("acks_seen_over_100", 64'(acks_seen > 100), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: compares outputs every cycle against the head of the expectation queue.
  initial begin
    txn_t          t;
    bit            have, e_busy, e_valid, e_err, fin;
    logic [NR-1:0] e_ack, e_dev;
    logic [31:0]   hold;
    int            c;
    t = '{default: 0};
    hold = '0;
    forever begin
      @(negedge clk);
      c = cyc;
      if (rst) begin
        hold = '0;
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_spi_valid", 64'(spi_valid), 64'(0));
        chk("rst_spi_data", 64'(spi_data), 64'(0));
        chk("rst_spi_bits", 64'(spi_bits), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_dev_cs", 64'(dev_cs), 64'hF);
      end else begin
        have = (exp_q.size() != 0);
        if (have) t = exp_q[0];
        e_valid = have && (c == t.g + 1 || c == t.g + 2);
        e_busy  = have && c >= t.g + 1 && c <= t.d + 1;
        fin     = have && c == t.d + 1;
        e_ack = '0;
        e_err = 0;
        e_dev = '1;
        if (e_busy) e_dev[t.idx] = spi_cs;
        if (fin) begin
          e_ack[t.idx] = 1'b1;
          e_err = t.err;
          hold  = t.rdata;
        end
        chk("ack", 64'(ack), 64'(e_ack));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("spi_valid", 64'(spi_valid), 64'(e_valid));
        chk("dev_cs", 64'(dev_cs), 64'(e_dev));
        chk("rdata", 64'(rdata), 64'(hold));
        chk("err", 64'(err), 64'(e_err));
        if (e_valid) begin
          chk("spi_data", 64'(spi_data), 64'(t.wdata));
          chk("spi_bits", 64'(spi_bits), 64'(t.bits));
        end
        if (fin) begin
          void'(exp_q.pop_front());
          acks_seen++;
        end
      end
    end
  end
endmodule
